tree_engine_scheduler: RTL and testbench

TREE_ENGINE_SCHEDULER -- requirements
Module: tree_engine_scheduler

---
 rtl/tree_sched_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/tree_engine_scheduler.sv | 134 +++++++++++++
 tb/tb_tree_engine_scheduler.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tree_sched_pkg.sv
// Shared types and default sizing for the tree-engine scheduler.
// The state enum is kept here so any tooling that decodes the FSM uses the same encoding.
package tree_sched_pkg;

  localparam int DEF_NUM_CH     = 4;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_TIMEOUT    = 64;
  localparam int DEF_CNT_WIDTH  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin channel picker: searches upward from the channel after the last grant
// and returns the first requester as both a one-hot vector and an index.
module rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int IW     = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] i_req,
  input  logic [IW-1:0]     i_last,
  output logic [NUM_CH-1:0] o_grant,
  output logic [IW-1:0]     o_idx,
  output logic              o_any
);

  always_comb begin
    int c;
    c       = 0;
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    for (int off = 1; off <= NUM_CH; off++) begin
      c = (int'(i_last) + off) % NUM_CH;
      if (!o_any && i_req[c]) begin
        o_any      = 1'b1;
        o_grant[c] = 1'b1;
        o_idx      = IW'(c);
      end
    end
  end

endmodule

// File: rtl/tree_engine_scheduler.sv
// Time-shares one isolation-tree engine among NUM_CH sensor channels, with an engine
// watchdog and sticky per-channel anomaly flags plus saturating anomaly counters.
module tree_engine_scheduler
  import tree_sched_pkg::*;
#(
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int TIMEOUT    = DEF_TIMEOUT,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_CH-1:0]             ch_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0]  ch_data,
  output logic [NUM_CH-1:0]             ch_ready,
  output logic [DATA_WIDTH-1:0]         eng_data,
  output logic                          eng_valid,
  input  logic                          eng_processed,
  input  logic                          eng_anomaly,
  output logic [NUM_CH-1:0]             anomaly_flags,
  input  logic [NUM_CH-1:0]             anomaly_clear,
  output logic [NUM_CH*CNT_WIDTH-1:0]   anomaly_count,
  output logic                          timeout_err,
  output logic                          busy,
  output logic [$clog2(NUM_CH)-1:0]     cur_ch
);

  localparam int IW = $clog2(NUM_CH);
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0]        T_LAST = TW'(TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] C_MAX  = '1;

  sched_state_t            r_state, w_next;
  logic [IW-1:0]           r_last, r_cur, w_grant_idx;
  logic [NUM_CH-1:0]       w_grant, w_set, r_flags;
  logic                    w_any, w_accept, w_complete, w_expire, r_timeout;
  logic [DATA_WIDTH-1:0]   r_data, w_sel_data;
  logic [TW-1:0]           r_timer;
  logic [CNT_WIDTH-1:0]    r_cnt [NUM_CH];

  rr_arbiter #(.NUM_CH(NUM_CH), .IW(IW)) u_arb (
    .i_req   (ch_valid),
    .i_last  (r_last),
    .o_grant (w_grant),
    .o_idx   (w_grant_idx),
    .o_any   (w_any)
  );

  assign w_sel_data = ch_data[int'(w_grant_idx)*DATA_WIDTH +: DATA_WIDTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // ch_ready is masked by reset so no transfer can be signalled before the first live edge.
  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_complete = 1'b0;
    w_expire   = 1'b0;
    ch_ready   = '0;
    case (r_state)
      IDLE: begin
        if (w_any && !reset) begin
          w_accept = 1'b1;
          ch_ready = w_grant;
          w_next   = RUN;
        end
      end
      RUN: begin
        if (eng_processed) begin
          w_complete = 1'b1;
          w_next     = DONE;
        end else if (r_timer == T_LAST) begin
          w_expire = 1'b1;
          w_next   = DONE;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_set = '0;
    if (w_complete && eng_anomaly) w_set[r_cur] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last    <= IW'(NUM_CH - 1);
      r_cur     <= '0;
      r_data    <= '0;
      r_timer   <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_expire;
      if (w_accept) begin
        r_last  <= w_grant_idx;
        r_cur   <= w_grant_idx;
        r_data  <= w_sel_data;
        r_timer <= '0;
      end else if (r_state == RUN) begin
        r_timer <= r_timer + 1'b1;
      end
    end
  end

  // A set in the same cycle as a clear on that channel leaves the flag high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flags <= '0;
      for (int i = 0; i < NUM_CH; i++) r_cnt[i] <= '0;
    end else begin
      r_flags <= (r_flags & ~anomaly_clear) | w_set;
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_set[i] && (r_cnt[i] != C_MAX)) r_cnt[i] <= r_cnt[i] + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt
    assign anomaly_count[g*CNT_WIDTH +: CNT_WIDTH] = r_cnt[g];
  end

  assign eng_valid     = (r_state == RUN);
  assign busy          = (r_state != IDLE);
  assign eng_data      = r_data;
  assign cur_ch        = r_cur;
  assign timeout_err   = r_timeout;
  assign anomaly_flags = r_flags;

endmodule

// File: tb/tb_tree_engine_scheduler.sv
// Scoreboard bench: a transaction-timeline model predicts grants, engine windows, timeouts
// and flag/count state; a negedge monitor compares the DUT against those predictions.
module tb_tree_engine_scheduler;

  localparam int NUM_CH  = 4;
  localparam int DW      = 8;
  localparam int TIMEOUT = 64;
  localparam int CW      = 8;
  localparam int CMAX    = (1 << CW) - 1;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NUM_CH-1:0]     ch_valid;
  logic [NUM_CH*DW-1:0]  ch_data;
  logic [NUM_CH-1:0]     ch_ready;
  logic [DW-1:0]         eng_data;
  logic                  eng_valid;
  logic                  eng_processed;
  logic                  eng_anomaly;
  logic [NUM_CH-1:0]     anomaly_flags;
  logic [NUM_CH-1:0]     anomaly_clear;
  logic [NUM_CH*CW-1:0]  anomaly_count;
  logic                  timeout_err;
  logic                  busy;
  logic [1:0]            cur_ch;

  tree_engine_scheduler #(
    .NUM_CH(NUM_CH), .DATA_WIDTH(DW), .TIMEOUT(TIMEOUT), .CNT_WIDTH(CW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .ch_valid      (ch_valid),
    .ch_data       (ch_data),
    .ch_ready      (ch_ready),
    .eng_data      (eng_data),
    .eng_valid     (eng_valid),
    .eng_processed (eng_processed),
    .eng_anomaly   (eng_anomaly),
    .anomaly_flags (anomaly_flags),
    .anomaly_clear (anomaly_clear),
    .anomaly_count (anomaly_count),
    .timeout_err   (timeout_err),
    .busy          (busy),
    .cur_ch        (cur_ch)
  );

  always #5 clk = ~clk;

  int checkCount = 0;
  int failCount  = 0;

  typedef struct {
    int            ch;
    logic [DW-1:0] data;
  } grant_t;

  grant_t            grantQ[$];
  bit [NUM_CH-1:0]   mPend, mFlags, clrDriven, mExpReady;
  logic [DW-1:0]     mData [NUM_CH];
  int                mCnt [NUM_CH];
  int                mLast, mCur, mRun, mRespAt, pendGrant, mTxnCount;
  bit                mActive, mInDone, mExpTimeout, procReal, procAnom;

  bit [NUM_CH-1:0]   cfgChEn, cfgClrForce;
  int                cfgReqPct, cfgMode, cfgLat, cfgAnomPct, cfgClrPct, cfgSpurPct;
  int                cfgNeverPct, cfgCoinPct;
  bit                cfgNeverOnce, cfgCoincideOnce;

  bit                monOn, prevEv;
  int                grantLog[$];
  int                runLenLog[$];
  int                curRunLen, toPulses, expCh;
  logic [DW-1:0]     expData;
  grant_t            popped;
  logic [NUM_CH*CW-1:0] expCntVec;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checkCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic failNow(input string name);
    checkCount++;
    failCount++;
    $display("[TB] FAIL %s at %0t", name, $time);
  endtask

  function automatic int rrPick(input bit [NUM_CH-1:0] req, input int last);
    for (int off = 1; off <= NUM_CH; off++) begin
      int c;
      c = (last + off) % NUM_CH;
      if (req[c]) return c;
    end
    return -1;
  endfunction

  // One call per cycle, just after the rising edge: settle what that edge did, then drive the new cycle.
  task automatic applyStimulus();
    bit [NUM_CH-1:0] setV;
    bit              toNow;
    int              r;
    grant_t          g;
    setV  = '0;
    toNow = 1'b0;
    if (mInDone) mInDone = 1'b0;
    else if (mActive) begin
      if (procReal) begin
        if (procAnom) setV[mCur] = 1'b1;
        mActive = 1'b0;
        mInDone = 1'b1;
      end else if (mRun == TIMEOUT) begin
        mActive = 1'b0;
        mInDone = 1'b1;
        toNow   = 1'b1;
      end
    end
    if (pendGrant >= 0) begin
      mActive = 1'b1;
      mRun    = 0;
      mCur    = pendGrant;
      mLast   = pendGrant;
      mPend[pendGrant] = 1'b0;
      g.ch   = pendGrant;
      g.data = mData[pendGrant];
      grantQ.push_back(g);
      mTxnCount++;
      if (cfgNeverOnce) begin
        mRespAt = 0; cfgNeverOnce = 1'b0;
      end else if (cfgCoincideOnce) begin
        mRespAt = TIMEOUT; cfgCoincideOnce = 1'b0;
      end else if (cfgMode == 1) begin
        mRespAt = cfgLat;
      end else begin
        r = int'($urandom % 100);
        if (r < cfgNeverPct) mRespAt = 0;
        else if (r < cfgNeverPct + cfgCoinPct) mRespAt = TIMEOUT;
        else mRespAt = int'($urandom_range(1, 10));
      end
      pendGrant = -1;
    end
    mFlags = (mFlags & ~clrDriven) | setV;
    for (int i = 0; i < NUM_CH; i++)
      if (setV[i] && mCnt[i] < CMAX) mCnt[i]++;
    mExpTimeout = toNow;

    procReal  = 1'b0;
    procAnom  = 1'b0;
    clrDriven = cfgClrForce;
    for (int i = 0; i < NUM_CH; i++)
      if (int'($urandom % 100) < cfgClrPct) clrDriven[i] = 1'b1;
    anomaly_clear = clrDriven;
    if (mActive) begin
      mRun++;
      procReal      = (mRun == mRespAt);
      procAnom      = int'($urandom % 100) < cfgAnomPct;
      eng_processed = procReal;
      eng_anomaly   = procAnom;
    end else begin
      eng_processed = int'($urandom % 100) < cfgSpurPct;
      eng_anomaly   = 1'b1;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (!mPend[i] && cfgChEn[i] && int'($urandom % 100) < cfgReqPct) begin
        mPend[i] = 1'b1;
        mData[i] = DW'($urandom);
      end
      ch_data[i*DW +: DW] = mData[i];
    end
    ch_valid = mPend;
    if (!mActive && !mInDone && mPend != '0) pendGrant = rrPick(mPend, mLast);
    mExpReady = '0;
    if (pendGrant >= 0) mExpReady[pendGrant] = 1'b1;
  endtask

  task automatic runCycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      applyStimulus();
    end
  endtask

  task automatic waitTxn(input int target, input int bound, input string name);
    int k;
    k = 0;
    while (mTxnCount < target && k < bound) begin
      @(posedge clk); #1;
      applyStimulus();
      k++;
    end
    if (mTxnCount < target) failNow(name);
  endtask

  task automatic resetModel();
    mActive = 0; mInDone = 0; mExpTimeout = 0; procReal = 0; procAnom = 0;
    mLast = NUM_CH - 1; mCur = 0; mRun = 0; mRespAt = 0; pendGrant = -1;
    mFlags = '0; clrDriven = '0; mExpReady = '0; mPend = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      mCnt[i]  = 0;
      mData[i] = '0;
    end
    grantQ.delete();
    prevEv = 1'b0;
    eng_processed = 1'b0; eng_anomaly = 1'b0; anomaly_clear = '0;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_eng_valid"}, eng_valid, 0);
    checkOutput({tag, "_eng_data"}, eng_data, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_flags"}, anomaly_flags, 0);
    checkOutput({tag, "_count"}, anomaly_count, 0);
    checkOutput({tag, "_timeout"}, timeout_err, 0);
    checkOutput({tag, "_cur_ch"}, cur_ch, 0);
    ch_valid = '1;
    #1;
    checkOutput({tag, "_ch_ready"}, ch_ready, 0);
  endtask

  task automatic setCfg(input bit [NUM_CH-1:0] en, input int reqPct, input int mode, input int lat,
                        input int anomPct, input int spurPct);
    cfgChEn = en; cfgReqPct = reqPct; cfgMode = mode; cfgLat = lat;
    cfgAnomPct = anomPct; cfgSpurPct = spurPct;
    cfgClrForce = '0; cfgClrPct = 0; cfgNeverPct = 0; cfgCoinPct = 0;
  endtask

  always @(negedge clk) begin
    if (monOn && !reset) begin
      checkOutput("eng_valid", eng_valid, mActive);
      checkOutput("busy", busy, mActive || mInDone);
      checkOutput("ch_ready", ch_ready, mExpReady);
      checkOutput("timeout_err", timeout_err, mExpTimeout);
      checkOutput("anomaly_flags", anomaly_flags, mFlags);
      for (int i = 0; i < NUM_CH; i++) expCntVec[i*CW +: CW] = CW'(mCnt[i]);
      checkOutput("anomaly_count", anomaly_count, expCntVec);
      if (timeout_err) toPulses++;
      if (eng_valid && !prevEv) begin
        if (grantQ.size() == 0) failNow("unexpected_engine_issue");
        else begin
          popped  = grantQ.pop_front();
          expCh   = popped.ch;
          expData = popped.data;
          checkOutput("cur_ch", cur_ch, expCh);
          checkOutput("eng_data", eng_data, expData);
          grantLog.push_back(int'(cur_ch));
          curRunLen = 0;
        end
      end else if (eng_valid) begin
        checkOutput("eng_data_stable", eng_data, expData);
      end
      if (eng_valid) curRunLen++;
      if (!eng_valid && prevEv) runLenLog.push_back(curRunLen);
      prevEv = eng_valid;
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int k;
    reset = 1'b1; monOn = 1'b0; ch_valid = '0; ch_data = '0;
    toPulses = 0; curRunLen = 0; expCh = 0; expData = '0; mTxnCount = 0;
    cfgNeverOnce = 0; cfgCoincideOnce = 0;
    resetModel();
    setCfg('0, 0, 1, 5, 100, 0);
    repeat (3) @(posedge clk);
    #1;
    checkResetValues("rst_init");

    // Lone request on channel 0, verdict anomalous after five engine cycles.
    resetModel();
    mPend[0] = 1'b1; mData[0] = 8'hA5;
    reset = 1'b0; monOn = 1'b1;
    applyStimulus();
    runCycles(12);
    checkOutput("single_flags", anomaly_flags, 4'b0001);
    checkOutput("single_count0", anomaly_count[CW-1:0], 1);
    checkOutput("single_len", (runLenLog.size() > 0) ? runLenLog[0] : -1, 5);

    // Reset hits in the middle of a long engine run.
    setCfg('0, 0, 1, 20, 0, 0);
    mPend[1] = 1'b1; mData[1] = 8'h3C;
    k = 0;
    while (!(mActive && mRun >= 3) && k < 30) begin
      @(posedge clk); #1; applyStimulus(); k++;
    end
    if (!(mActive && mRun >= 3)) failNow("wait_mid_run");
    #2;
    reset = 1'b1; monOn = 1'b0;
    #1;
    checkResetValues("rst_mid");
    resetModel();
    @(posedge clk); #1;
    checkOutput("rst_hold_ready", ch_ready, 0);

    // All channels streaming, quick clean verdicts: strict rotation starting at channel 0.
    setCfg(4'b1111, 100, 1, 2, 0, 0);
    grantLog.delete();
    reset = 1'b0; monOn = 1'b1;
    applyStimulus();
    runCycles(24);
    if (grantLog.size() < 5) failNow("rr_log_short");
    else begin
      checkOutput("rr_g0", grantLog[0], 0);
      checkOutput("rr_g1", grantLog[1], 1);
      checkOutput("rr_g2", grantLog[2], 2);
      checkOutput("rr_g3", grantLog[3], 3);
      checkOutput("rr_g4", grantLog[4], 0);
    end
    checkOutput("rr_flags", anomaly_flags, 0);

    // Silent engine: watchdog ends the window, then the other requester is served.
    cfgReqPct = 0;
    runCycles(24);
    toPulses = 0; runLenLog.delete(); grantLog.delete();
    cfgNeverOnce = 1'b1; cfgAnomPct = 100;
    mPend[1] = 1'b1; mData[1] = 8'h11;
    mPend[2] = 1'b1; mData[2] = 8'h22;
    waitTxn(mTxnCount + 2, 120, "wait_timeout_txns");
    runCycles(8);
    checkOutput("to_len", (runLenLog.size() > 0) ? runLenLog[0] : -1, TIMEOUT);
    checkOutput("to_pulses", toPulses, 1);
    checkOutput("to_next_differs", (grantLog.size() > 1) && (grantLog[0] != grantLog[1]), 1);
    checkOutput("to_pair", (grantLog.size() > 1) ? grantLog[0] + grantLog[1] : -1, 3);

    // Completion in the final allowed cycle, plus engine pulses while idle.
    toPulses = 0; cfgSpurPct = 50;
    cfgCoincideOnce = 1'b1;
    mPend[3] = 1'b1; mData[3] = 8'h77;
    waitTxn(mTxnCount + 1, 10, "wait_coincide");
    runCycles(TIMEOUT + 12);
    checkOutput("coin_count3", anomaly_count[3*CW +: CW], 1);
    checkOutput("coin_flag3", anomaly_flags[3], 1);
    checkOutput("coin_pulses", toPulses, 0);

    // Channel 2 hammered with anomalies while its clear is held: counter saturates.
    setCfg(4'b0100, 100, 1, 1, 100, 0);
    cfgClrForce = 4'b0100;
    waitTxn(mTxnCount + 300, 1500, "wait_saturate");
    cfgReqPct = 0;
    runCycles(6);
    checkOutput("sat_count2", anomaly_count[2*CW +: CW], CMAX);
    cfgClrForce = '0;
    mPend[2] = 1'b1; mData[2] = 8'h5A;
    runCycles(6);
    checkOutput("sat_flag2", anomaly_flags[2], 1);
    checkOutput("sat_count2_hold", anomaly_count[2*CW +: CW], CMAX);

    // Free-running random traffic.
    setCfg(4'b1111, 30, 0, 0, 50, 10);
    cfgClrPct = 10; cfgNeverPct = 5; cfgCoinPct = 3;
    runCycles(3000);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
